// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// This file holds the stack-iteration state encoding, the Iter_Num values,
// the latched stack-op class and the default register-address width. The
// decode and execute sides both use it.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 3;

  // Stack-iteration FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ITER2 = 2'd1;
  localparam logic [1:0] ST_ITER3 = 2'd2;

  // Iter_Num values reported to decode
  localparam logic [1:0] ITER_NUM_FIRST  = 2'd0;
  localparam logic [1:0] ITER_NUM_SECOND = 2'd1;
  localparam logic [1:0] ITER_NUM_THIRD  = 2'd2;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_CALL = 2'd1,
    OP_RET  = 2'd2,
    OP_RTI  = 2'd3
  } stack_op_e;

  function automatic logic [1:0] iter_num_of(input logic [1:0] state);
    case (state)
      ST_ITER2: iter_num_of = ITER_NUM_SECOND;
      ST_ITER3: iter_num_of = ITER_NUM_THIRD;
      default:  iter_num_of = ITER_NUM_FIRST;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_stack_iter_fsm.sv
// Multi-iteration sequencer for CALL / RET / RTI.
// CALL and RET issue twice. RTI issues three times. The op class is captured
// when the sequence starts, so later changes on Dec_* have no effect on it.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   dec_valid      decode holds a valid instruction
//   dec_call/ret/rti  decoded multi-iteration stack op
//   taken          branch taken in execute: abort the sequence to IDLE
//   load_use       load-use stall: hold the current state
//   in_seq         FSM is in ITER2 or ITER3
//   iter_num       0 / 1 / 2 for the first / second / third iteration
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no sequence; first iteration issues from decode
// ITER2 | second iteration of CALL/RET/RTI
// ITER3 | third iteration (RTI only)
module stack_iter_fsm
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic       dec_call,
  input  logic       dec_ret,
  input  logic       dec_rti,
  input  logic       taken,
  input  logic       load_use,
  output logic       in_seq,
  output logic [1:0] iter_num
);

  logic [1:0] state_q, state_d;
  stack_op_e  op_q, op_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    if (taken) begin
      state_d = ST_IDLE;
    end else if (!load_use) begin
      case (state_q)
        ST_IDLE: begin
          if (dec_valid && (dec_call || dec_ret || dec_rti)) begin
            state_d = ST_ITER2;
            op_d    = dec_rti ? OP_RTI : (dec_ret ? OP_RET : OP_CALL);
          end
        end
        ST_ITER2: state_d = (op_q == OP_RTI) ? ST_ITER3 : ST_IDLE;
        ST_ITER3: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign in_seq   = (state_q != ST_IDLE);
  assign iter_num = iter_num_of(state_q);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller.
// This module detects load-use hazards and taken jumps, and drives the stall,
// bubble and flush controls. It also sequences the multi-iteration stack ops
// through stack_iter_fsm.
//
// Ports:
//   CLK, Reset                      clock, synchronous active-high reset
//   Dec_*                           decode-stage instruction info
//   Ex_MemRead, Ex_WB, Ex_RdstAddr  execute-stage load info
//   Ex_JMP/JZ/JN/JC, ZF/NF/CF       execute-stage jump type and flags
//   Stall_PC, Stall_IFID, Bubble_EX stall and bubble controls
//   Flush_IFID, Flush_IDEX          wrong-path squash
//   ScndIteration, Iter_Num         stack-iteration status
//   PrvsStackOp                     a stack op issued in the previous cycle
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Dec_Valid,
  input  logic                  Dec_CALL,
  input  logic                  Dec_RET,
  input  logic                  Dec_RTI,
  input  logic                  Dec_PUSH,
  input  logic                  Dec_POP,
  input  logic                  Dec_UseRsrc,
  input  logic                  Dec_UseRdst,
  input  logic [REG_ADDR_W-1:0] Dec_RsrcAddr,
  input  logic [REG_ADDR_W-1:0] Dec_RdstAddr,
  input  logic                  Ex_MemRead,
  input  logic                  Ex_WB,
  input  logic [REG_ADDR_W-1:0] Ex_RdstAddr,
  input  logic                  Ex_JMP,
  input  logic                  Ex_JZ,
  input  logic                  Ex_JN,
  input  logic                  Ex_JC,
  input  logic                  ZF,
  input  logic                  NF,
  input  logic                  CF,
  output logic                  Stall_PC,
  output logic                  Stall_IFID,
  output logic                  Bubble_EX,
  output logic                  Flush_IFID,
  output logic                  Flush_IDEX,
  output logic                  ScndIteration,
  output logic [1:0]            Iter_Num,
  output logic                  PrvsStackOp
);

  logic taken;
  logic load_use;
  logic in_seq;
  logic stack_op_dec;
  logic stall;
  logic prvs_stack_op_q, prvs_stack_op_d;

  always_comb begin
    taken = Ex_JMP | (Ex_JZ & ZF) | (Ex_JN & NF) | (Ex_JC & CF);
    load_use = Ex_MemRead & Ex_WB & Dec_Valid &
               ((Dec_UseRsrc & (Dec_RsrcAddr == Ex_RdstAddr)) |
                (Dec_UseRdst & (Dec_RdstAddr == Ex_RdstAddr)));
    stack_op_dec = Dec_Valid & (Dec_CALL | Dec_RET | Dec_RTI | Dec_PUSH | Dec_POP);
    // A taken jump overrides every stall source; the flush wins.
    stall = !taken && (load_use || in_seq);
    // A stack op leaves decode in any iteration. In IDLE the first issue is
    // taken from decode; in ITER2/ITER3 the later iterations of the held op
    // issue. The issue does not count if a load-use stall or a flush stops it.
    prvs_stack_op_d = !taken && !load_use && (in_seq || stack_op_dec);
  end

  stack_iter_fsm u_stack_iter_fsm (
    .clk       (CLK),
    .rst       (Reset),
    .dec_valid (Dec_Valid),
    .dec_call  (Dec_CALL),
    .dec_ret   (Dec_RET),
    .dec_rti   (Dec_RTI),
    .taken     (taken),
    .load_use  (load_use),
    .in_seq    (in_seq),
    .iter_num  (Iter_Num)
  );

  always_ff @(posedge CLK) begin
    if (Reset) prvs_stack_op_q <= 1'b0;
    else       prvs_stack_op_q <= prvs_stack_op_d;
  end

  assign Stall_PC      = stall;
  assign Stall_IFID    = stall;
  assign Bubble_EX     = !taken && load_use;
  assign Flush_IFID    = taken;
  assign Flush_IDEX    = taken;
  assign ScndIteration = in_seq;
  assign PrvsStackOp   = prvs_stack_op_q;

endmodule
